// File: rtl/dxl_pkg.sv
// dxl_pkg: shared types, constants and helpers for the Dynamixel status parser.
// C_DXL_TIMEOUT only matters when DXL_PARSER_TIMEOUT_EN is defined.
package dxl_pkg;

    typedef enum logic [2:0] {
        S_HDR1,
        S_HDR2,
        S_ID,
        S_LEN,
        S_ERR,
        S_PARAM,
        S_CSUM,
        S_HOLD
    } dxl_state_e;

    localparam logic [7:0]  C_DXL_HDR     = 8'hFF;
    localparam logic [15:0] C_DXL_TIMEOUT = 16'd64;

    function automatic logic [7:0] dxl_csum(input logic [7:0] sum);
        return ~sum;
    endfunction

    function automatic logic [7:0] dxl_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dxl_param_buf.sv
// dxl_param_buf: parameter byte store, one synchronous write port and
// one combinational read port. Contents are not reset.
module dxl_param_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i && int'(waddr_i) < DEPTH) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : 8'h00;

endmodule

// File: rtl/dxl_status_parser.sv
// dxl_status_parser: Dynamixel 1.0 status packet parser with checksum check.
// Define DXL_PARSER_TIMEOUT_EN to abort partial packets after an inter-byte gap.
module dxl_status_parser
    import dxl_pkg::*;
#(
    parameter int MAX_PARAMS = 8,
    localparam int NW = $clog2(MAX_PARAMS + 1),
    localparam int AW = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          pkt_valid,
    input  logic          pkt_ready,
    output logic [7:0]    pkt_id,
    output logic [7:0]    pkt_err,
    output logic [NW-1:0] pkt_nparam,
    input  logic [AW-1:0] param_idx,
    output logic [7:0]    param_data,
    output logic [7:0]    csum_err_cnt,
    output logic [7:0]    len_err_cnt
);

    localparam logic [7:0] LEN_MAX = 8'(MAX_PARAMS + 2);

    dxl_state_e    state_q, state_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    id_q, id_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    cerr_q, cerr_d;
    logic [7:0]    lerr_q, lerr_d;
    logic [NW-1:0] np_q, np_d;
    logic [NW-1:0] k_q, k_d;
    logic          accept;
    logic          buf_we;
`ifdef DXL_PARSER_TIMEOUT_EN
    logic [15:0]   gap_q, gap_d;
    logic          idle_st;
`endif

    assign in_ready     = (state_q != S_HOLD);
    assign pkt_valid    = (state_q == S_HOLD);
    assign accept       = in_valid && in_ready;
    assign pkt_id       = id_q;
    assign pkt_err      = err_q;
    assign pkt_nparam   = np_q;
    assign csum_err_cnt = cerr_q;
    assign len_err_cnt  = lerr_q;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        id_d    = id_q;
        err_d   = err_q;
        cerr_d  = cerr_q;
        lerr_d  = lerr_q;
        np_d    = np_q;
        k_d     = k_q;
        buf_we  = 1'b0;
        unique case (state_q)
            S_HDR1: begin
                if (accept && in_data == C_DXL_HDR) state_d = S_HDR2;
            end
            S_HDR2: begin
                if (accept) state_d = (in_data == C_DXL_HDR) ? S_ID : S_HDR1;
            end
            S_ID: begin
                if (accept && in_data != C_DXL_HDR) begin
                    id_d    = in_data;
                    sum_d   = in_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (in_data < 8'd2 || in_data > LEN_MAX) begin
                        lerr_d  = dxl_sat_inc(lerr_q);
                        state_d = S_HDR1;
                    end else begin
                        np_d    = NW'(in_data - 8'd2);
                        sum_d   = sum_q + in_data;
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                if (accept) begin
                    err_d   = in_data;
                    sum_d   = sum_q + in_data;
                    k_d     = '0;
                    state_d = (np_q != '0) ? S_PARAM : S_CSUM;
                end
            end
            S_PARAM: begin
                if (accept) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + in_data;
                    k_d    = k_q + NW'(1);
                    if (k_q == np_q - NW'(1)) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == dxl_csum(sum_q)) begin
                        state_d = S_HOLD;
                    end else begin
                        cerr_d  = dxl_sat_inc(cerr_q);
                        state_d = S_HDR1;
                    end
                end
            end
            S_HOLD: begin
                if (pkt_ready) state_d = S_HDR1;
            end
            default: state_d = S_HDR1;
        endcase
`ifdef DXL_PARSER_TIMEOUT_EN
        idle_st = (state_q == S_HDR1) || (state_q == S_HOLD);
        gap_d   = (accept || idle_st) ? 16'd0 : gap_q + 16'd1;
        // A byte landing on the expiry cycle is parsed as a fresh HDR1 byte.
        if (!idle_st && gap_q == C_DXL_TIMEOUT) begin
            state_d = (accept && in_data == C_DXL_HDR) ? S_HDR2 : S_HDR1;
            buf_we  = 1'b0;
            cerr_d  = cerr_q;
            lerr_d  = lerr_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_HDR1;
            sum_q   <= '0;
            id_q    <= '0;
            err_q   <= '0;
            cerr_q  <= '0;
            lerr_q  <= '0;
            np_q    <= '0;
            k_q     <= '0;
`ifdef DXL_PARSER_TIMEOUT_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            err_q   <= err_d;
            cerr_q  <= cerr_d;
            lerr_q  <= lerr_d;
            np_q    <= np_d;
            k_q     <= k_d;
`ifdef DXL_PARSER_TIMEOUT_EN
            gap_q   <= gap_d;
`endif
        end
    end

    dxl_param_buf #(
        .DEPTH (MAX_PARAMS),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (k_q[AW-1:0]),
        .wdata_i (in_data),
        .raddr_i (param_idx),
        .rdata_o (param_data)
    );

endmodule

// File: tb/tb_dxl_status_parser.sv
// tb_dxl_status_parser: table-driven stream vectors with a packet scoreboard,
// plus hand sequences for reset, back-pressure, timeout and saturation.
module tb_dxl_status_parser;
    import dxl_pkg::*;

    localparam int NW = 4;
    localparam int AW = 3;
    localparam int NV = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          pkt_valid;
    logic          pkt_ready = 1'b0;
    logic [7:0]    pkt_id;
    logic [7:0]    pkt_err;
    logic [NW-1:0] pkt_nparam;
    logic [AW-1:0] param_idx = '0;
    logic [7:0]    param_data;
    logic [7:0]    csum_err_cnt;
    logic [7:0]    len_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_exp    = 0;
    int n_seen   = 0;
    bit hold_ack = 1'b0;

    typedef struct {
        int          nb;
        logic [127:0] b;
        bit          pkt;
        logic [7:0]  id;
        logic [7:0]  err;
        int          np;
        logic [63:0] p;
        logic [7:0]  cerr;
        logic [7:0]  lerr;
    } vec_t;

    typedef struct {
        logic [7:0]  id;
        logic [7:0]  err;
        int          np;
        logic [63:0] p;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[NV];

    dxl_status_parser dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_id       (pkt_id),
        .pkt_err      (pkt_err),
        .pkt_nparam   (pkt_nparam),
        .param_idx    (param_idx),
        .param_data   (param_data),
        .csum_err_cnt (csum_err_cnt),
        .len_err_cnt  (len_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int nb, input logic [127:0] b,
                                input bit pkt, input logic [7:0] id,
                                input logic [7:0] err, input int np,
                                input logic [63:0] p, input logic [7:0] cerr,
                                input logic [7:0] lerr);
        vec_t v;
        v.nb = nb; v.b = b; v.pkt = pkt; v.id = id; v.err = err;
        v.np = np; v.p = p; v.cerr = cerr; v.lerr = lerr;
        return v;
    endfunction

    task automatic expect_pkt(input logic [7:0] id, input logic [7:0] err,
                              input int np, input logic [63:0] p);
        exp_t e;
        e.id = id; e.err = err; e.np = np; e.p = p;
        sb.push_back(e);
        n_exp++;
    endtask

    task automatic send(input int nb, input logic [127:0] b);
        for (int i = 0; i < nb; i++) begin
            int t;
            t = 0;
            in_valid = 1'b1;
            in_data  = b[(nb-1-i)*8 +: 8];
            while (!in_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_wait: in_ready got 0 expected 1");
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin : consumer
        forever begin
            @(negedge clk);
            if (pkt_valid) begin
                n_seen++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pkt: got id 0x%0h expected none",
                             pkt_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pkt_id", 32'(pkt_id), 32'(e.id));
                    check("pkt_err", 32'(pkt_err), 32'(e.err));
                    check("pkt_nparam", 32'(pkt_nparam), 32'(e.np));
                    for (int i = 0; i < e.np; i++) begin
                        param_idx = AW'(i);
                        #1;
                        check($sformatf("param_data[%0d]", i), 32'(param_data),
                              32'(e.p[(e.np-1-i)*8 +: 8]));
                    end
                end
                @(negedge clk);
                while (hold_ack) @(negedge clk);
                pkt_ready = 1'b1;
                @(negedge clk);
                pkt_ready = 1'b0;
                check("valid_drop", 32'(pkt_valid), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok_rdy, ok_vld, ok_out;
        vecs[0] = mk(6, 128'hFFFF010200FC, 1, 8'h01, 8'h00, 0, 64'h0, 0, 0);
        vecs[1] = mk(8, 128'hFFFF0104002000DA, 1, 8'h01, 8'h00, 2,
                     64'h2000, 0, 0);
        vecs[2] = mk(6, 128'hFFFF010200FB, 0, 0, 0, 0, 64'h0, 1, 0);
        vecs[3] = mk(6, 128'hFFFF010200FC, 1, 8'h01, 8'h00, 0, 64'h0, 1, 0);
        vecs[4] = mk(8, 128'h55FFFFFF030200FA, 1, 8'h03, 8'h00, 0,
                     64'h0, 1, 0);
        vecs[5] = mk(4, 128'hFFFF010B, 0, 0, 0, 0, 64'h0, 1, 1);
        vecs[6] = mk(4, 128'hFFFF0101, 0, 0, 0, 0, 64'h0, 1, 2);
        vecs[7] = mk(14, 128'hFFFF050A0711223344556677_8885, 1, 8'h05,
                     8'h07, 8, 64'h1122334455667788, 1, 2);
        vecs[8] = mk(7, 128'hFFFF070324AB26, 1, 8'h07, 8'h24, 1,
                     64'hAB, 1, 2);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pkt_valid", 32'(pkt_valid), 0);
        check("rst_pkt_id", 32'(pkt_id), 0);
        check("rst_pkt_err", 32'(pkt_err), 0);
        check("rst_pkt_nparam", 32'(pkt_nparam), 0);
        check("rst_csum_cnt", 32'(csum_err_cnt), 0);
        check("rst_len_cnt", 32'(len_err_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].pkt)
                expect_pkt(vecs[i].id, vecs[i].err, vecs[i].np, vecs[i].p);
            send(vecs[i].nb, vecs[i].b);
            repeat (6) @(negedge clk);
            check($sformatf("v%0d_csum_cnt", i), 32'(csum_err_cnt),
                  32'(vecs[i].cerr));
            check($sformatf("v%0d_len_cnt", i), 32'(len_err_cnt),
                  32'(vecs[i].lerr));
            check($sformatf("v%0d_drained", i), 32'(sb.size()), 0);
        end

        // Reset mid-packet drops the partial packet and clears counters.
        send(5, 128'hFFFF010200);
        in_valid = 1'b1;
        in_data  = 8'hFC;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        check("midrst_csum_cnt", 32'(csum_err_cnt), 0);
        check("midrst_len_cnt", 32'(len_err_cnt), 0);
        check("midrst_valid", 32'(pkt_valid), 0);
        expect_pkt(8'h01, 8'h00, 0, 64'h0);
        send(6, 128'hFFFF010200FC);
        repeat (6) @(negedge clk);
        check("midrst_drained", 32'(sb.size()), 0);
        check("midrst_csum_after", 32'(csum_err_cnt), 0);

        // Back-pressure: packet held 20 cycles while a byte waits.
        hold_ack = 1'b1;
        expect_pkt(8'h09, 8'h00, 0, 64'h0);
        send(6, 128'hFFFF090200F4);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        ok_rdy = 1'b1; ok_vld = 1'b1; ok_out = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) ok_rdy = 1'b0;
            if (pkt_valid !== 1'b1) ok_vld = 1'b0;
            if (pkt_id !== 8'h09 || pkt_err !== 8'h00 || pkt_nparam !== '0)
                ok_out = 1'b0;
        end
        check("hold_in_ready_low", 32'(ok_rdy), 1);
        check("hold_valid_high", 32'(ok_vld), 1);
        check("hold_outputs_stable", 32'(ok_out), 1);
        expect_pkt(8'h0A, 8'h00, 0, 64'h0);
        hold_ack = 1'b0;
        send(6, 128'hFFFF0A0200F3);
        repeat (8) @(negedge clk);
        check("hold_resume_drained", 32'(sb.size()), 0);

`ifdef DXL_PARSER_TIMEOUT_EN
        send(3, 128'hFFFF01);
        repeat (int'(C_DXL_TIMEOUT)) @(negedge clk);
        expect_pkt(8'h02, 8'h00, 0, 64'h0);
        send(6, 128'hFFFF020200FB);
        repeat (6) @(negedge clk);
        check("tmo_drained", 32'(sb.size()), 0);
        check("tmo_csum_cnt", 32'(csum_err_cnt), 0);
        check("tmo_len_cnt", 32'(len_err_cnt), 0);
`endif

        for (int j = 0; j < 260; j++) send(6, 128'hFFFF010200FB);
        repeat (2) @(negedge clk);
        check("csum_cnt_saturate", 32'(csum_err_cnt), 255);
        check("len_cnt_after_sat", 32'(len_err_cnt), 0);

        check("pkts_seen", 32'(n_seen), 32'(n_exp));
        check("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
